// File: rtl/m_lsu.sv
// Memory-stage load/store unit: one request per handshake, wait-stated bus with byte enables, load extension.
// Optional macro M_LSU_ALIGN_EXC_EN turns misaligned accesses into err 1 instead of rounding them down.
module m_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [1:0]        size_q;
    logic [LANE_W-1:0] lane_q;
    logic              is_store_q;
    logic              is_unsigned_q;

    logic [1:0]        size;
    logic [LANE_W-1:0] lane_raw;
    logic [LANE_W-1:0] smask;
    logic [LANE_W-1:0] lane;
    logic              illegal;
    logic              misaligned;
    logic              accept;
    logic              timeout_hit;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_ext;

    assign accept      = req_valid && req_ready;
    assign size        = req_op[1:0];
    assign lane_raw    = req_addr[LANE_W-1:0];
    assign illegal     = (DATA_W == 32) && (size == 2'd3);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    assign req_ready  = (state == IDLE) && !reset;
    assign busy       = (state != IDLE);
    assign mem_req    = (state == BUS);
    assign resp_valid = (state == RESP);

    // smask covers the lane bits that lie inside one access of the given size
    always_comb begin
        smask = '0;
        case (size)
            2'd0:    smask = '0;
            2'd1:    smask = LANE_W'(1);
            2'd2:    smask = LANE_W'(3);
            default: smask = LANE_W'(7);
        endcase
`ifdef M_LSU_ALIGN_EXC_EN
        misaligned = |(lane_raw & smask);
        lane       = lane_raw;
`else
        misaligned = 1'b0;
        lane       = lane_raw & ~smask;
`endif
    end

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = !req_op[3] || ((i >= int'(lane)) && (i <= int'(lane | smask)));
            wdata_rep[8*i +: 8] = req_wdata[8*(i & int'(smask)) +: 8];
        end
    end

    always_comb begin
        int width;
        int msb;
        logic fill;
        width    = 8 << size_q;
        msb      = (width > DATA_W) ? DATA_W - 1 : width - 1;
        shifted  = mem_rdata >> (8 * int'(lane_q));
        fill     = !is_unsigned_q && shifted[msb];
        load_ext = shifted;
        for (int i = 0; i < DATA_W; i++) begin
            if (i > msb) load_ext[i] = fill;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (illegal || misaligned) ? RESP : BUS;
            BUS:  if (mem_ack || timeout_hit) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            size_q        <= '0;
            lane_q        <= '0;
            is_store_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            resp_err      <= '0;
            resp_rdata    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == BUS) ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                size_q        <= size;
                lane_q        <= lane;
                is_store_q    <= req_op[3];
                is_unsigned_q <= req_op[2];
                mem_we        <= req_op[3];
                mem_addr      <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                mem_be        <= be;
                mem_wdata     <= wdata_rep;
                resp_err      <= illegal ? 2'd3 : (misaligned ? 2'd1 : 2'd0);
                resp_rdata    <= '0;
            end
            // ack beats a simultaneous timeout expiry
            if (state == BUS) begin
                if (mem_ack) begin
                    resp_err   <= 2'd0;
                    resp_rdata <= is_store_q ? '0 : load_ext;
                end else if (timeout_hit) begin
                    resp_err   <= 2'd2;
                end
            end
        end
    end
endmodule

// File: tb/tb_m_lsu.sv
module tb_m_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    m_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

`ifdef M_LSU_ALIGN_EXC_EN
    localparam bit ALIGN_EXC = 1'b1;
`else
    localparam bit ALIGN_EXC = 1'b0;
`endif

    typedef struct {
        logic [1:0]  err;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] addr;
        logic        we;
        int          rcyc;
        int          mcyc;
        logic        extra;
    } res_t;

    // Reference: what an access should look like, derived from size/offset arithmetic.
    function automatic res_t model(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        res_t r;
        int nb, off;
        longint v, mask;
        nb = 1 << op[1:0];
        r.data = '0; r.extra = 1'b0; r.we = op[3];
        r.addr = addr & 32'hFFFF_FFFC;
        off = ((addr % 4) / nb) * nb;
        r.be = op[3] ? 4'(((1 << nb) - 1) << off) : 4'hF;
        for (int j = 0; j < 4; j++) r.wd[8*j +: 8] = wdata[8*(j % nb) +: 8];
        if (op[1:0] == 2'd3) begin
            r.err = 2'd3; r.rcyc = 1; r.mcyc = 0;
        end else if (ALIGN_EXC && (addr % nb) != 0) begin
            r.err = 2'd1; r.rcyc = 1; r.mcyc = 0;
        end else if (waits < 0 || waits >= TO) begin
            r.err = 2'd2; r.rcyc = TO + 1; r.mcyc = TO;
        end else begin
            r.err = 2'd0; r.rcyc = waits + 2; r.mcyc = waits + 1;
            if (!op[3]) begin
                mask = (64'd1 << (8 * nb)) - 1;
                v = (longint'(rdata) >> (8 * off)) & mask;
                if (!op[2] && ((v >> (8 * nb - 1)) & 1) != 0) v = v | ~mask;
                r.data = v[31:0];
            end
        end
        return r;
    endfunction

    // Drives one request and a memory that acks after 'waits' stalled cycles (never if waits < 0).
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits, output res_t r);
        int guard, k;
        bit got;
        r.err = 'x; r.data = 'x; r.be = 'x; r.wd = 'x; r.addr = 'x; r.we = 'x;
        r.rcyc = -1; r.mcyc = 0; r.extra = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; mem_rdata = rdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        for (k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (resp_valid) begin
                got = 1; r.rcyc = k; r.err = resp_err; r.data = resp_rdata;
            end
            if (mem_req) begin
                r.mcyc++;
                if (r.mcyc == 1) begin
                    r.be = mem_be; r.wd = mem_wdata; r.addr = mem_addr; r.we = mem_we;
                end
                if (waits >= 0 && r.mcyc == waits + 1) mem_ack = 1'b1;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        r.extra = resp_valid;
    endtask

    task automatic check(input string name, input res_t a, input res_t e);
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if ({mem_req, mem_we, resp_valid, busy, req_ready} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 00000", {mem_req, mem_we, resp_valid, busy, req_ready});
        end
        tests++;
        if ({resp_err, resp_rdata, mem_addr, mem_be, mem_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_data: err=%h rdata=%h addr=%h be=%h wdata=%h required all 0",
                     resp_err, resp_rdata, mem_addr, mem_be, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_directed;
        res_t a, e;
        run_txn(4'b0000, 32'h1003, 32'h0, 32'h80FF_1234, 0, a);
        tests++;
        if (a.data !== 32'hFFFF_FF80 || a.err !== 2'd0 || a.rcyc !== 2 || a.extra !== 1'b0) begin
            fails++;
            $display("FAIL lb_1003: data=%h err=%0d cyc=%0d extra=%b required FFFFFF80 0 2 0", a.data, a.err, a.rcyc, a.extra);
        end
        run_txn(4'b0100, 32'h1003, 32'h0, 32'h80FF_1234, 0, a);
        tests++;
        if (a.data !== 32'h0000_0080 || a.err !== 2'd0) begin
            fails++;
            $display("FAIL lbu_1003: data=%h err=%0d required 00000080 0", a.data, a.err);
        end
        run_txn(4'b1001, 32'h2002, 32'h0000_ABCD, 32'h0, 0, a);
        tests++;
        if (a.be !== 4'b1100 || a.wd !== 32'hABCD_ABCD || a.addr !== 32'h2000 || a.we !== 1'b1 || a.data !== '0) begin
            fails++;
            $display("FAIL sh_2002: be=%b wd=%h addr=%h we=%b data=%h required 1100 ABCDABCD 00002000 1 0",
                     a.be, a.wd, a.addr, a.we, a.data);
        end
        // three wait states also coincides with the last timeout cycle: ack must win
        run_txn(4'b0010, 32'h3000, 32'h0, 32'hDEAD_BEEF, 3, a);
        tests++;
        if (a.rcyc !== 5 || a.data !== 32'hDEAD_BEEF || a.err !== 2'd0 || a.mcyc !== 4) begin
            fails++;
            $display("FAIL lw_wait3: cyc=%0d data=%h err=%0d mreq=%0d required 5 DEADBEEF 0 4", a.rcyc, a.data, a.err, a.mcyc);
        end
        run_txn(4'b0001, 32'h0001, 32'h0, 32'h1234_8765, 0, a);
        e = model(4'b0001, 32'h0001, 32'h0, 32'h1234_8765, 0);
        tests++;
        if (a.err !== e.err || a.data !== e.data || a.mcyc !== e.mcyc || a.rcyc !== e.rcyc ||
            (e.mcyc != 0 && a.addr !== 32'h0)) begin
            fails++;
            $display("FAIL lh_0001: err=%0d data=%h mreq=%0d cyc=%0d addr=%h required %0d %h %0d %0d 00000000",
                     a.err, a.data, a.mcyc, a.rcyc, a.addr, e.err, e.data, e.mcyc, e.rcyc);
        end
        run_txn(4'b0011, 32'h4000, 32'h0, 32'h0, 0, a);
        tests++;
        if (a.err !== 2'd3 || a.mcyc !== 0 || a.rcyc !== 1 || a.data !== '0) begin
            fails++;
            $display("FAIL ld_illegal: err=%0d mreq=%0d cyc=%0d data=%h required 3 0 1 0", a.err, a.mcyc, a.rcyc, a.data);
        end
    endtask

    task automatic test_timeout;
        res_t a;
        int stray;
        run_txn(4'b0010, 32'h5000, 32'h0, 32'h1111_1111, -1, a);
        tests++;
        if (a.err !== 2'd2 || a.mcyc !== TO || a.rcyc !== TO + 1 || a.data !== '0 || a.extra !== 1'b0) begin
            fails++;
            $display("FAIL timeout: err=%0d mreq=%0d cyc=%0d data=%h extra=%b required 2 %0d %0d 0 0",
                     a.err, a.mcyc, a.rcyc, a.data, a.extra, TO, TO + 1);
        end
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            if (resp_valid || mem_req) stray++;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (resp_valid || mem_req) stray++;
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL stray_ack: %0d cycles with activity, required 0", stray);
        end
    endtask

    task automatic test_reset_mid_bus;
        res_t a;
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h6000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: mem_req=%b required 1", mem_req);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: mem_req=%b busy=%b ready=%b required 0 0 0", mem_req, busy, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midrst_resp: %0d responses, required 0", seen);
        end
        run_txn(4'b0101, 32'h6002, 32'h0, 32'hF00D_0000, 1, a);
        tests++;
        if (a.err !== 2'd0 || a.data !== 32'h0000_F00D || a.rcyc !== 3) begin
            fails++;
            $display("FAIL midrst_next: err=%0d data=%h cyc=%0d required 0 0000F00D 3", a.err, a.data, a.rcyc);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0011; req_addr = 32'h0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        req_valid = 1'b0;
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL b2b_err: %0d responses in 8 cycles, required 4", n);
        end
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h7000; mem_ack = 1'b1;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        tests++;
        if (n !== 3) begin
            fails++;
            $display("FAIL b2b_mem: %0d responses in 9 cycles, required 3", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random;
        res_t a, e;
        logic [3:0]  op;
        logic [31:0] addr, wd, rd;
        int waits;
        for (int n = 0; n < 60; n++) begin
            op    = {1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2))};
            addr  = $urandom & 32'h0000_FFFF;
            wd    = $urandom;
            rd    = $urandom;
            waits = $urandom_range(0, 5);
            e = model(op, addr, wd, rd, waits);
            run_txn(op, addr, wd, rd, waits, a);
            tests++;
            if (a.err !== e.err || a.data !== e.data || a.rcyc !== e.rcyc || a.mcyc !== e.mcyc || a.extra !== 1'b0 ||
                (e.mcyc != 0 && (a.be !== e.be || a.wd !== e.wd || a.addr !== e.addr || a.we !== e.we))) begin
                fails++;
                $display("FAIL rand_%0d op=%b addr=%h: err=%0d data=%h cyc=%0d mreq=%0d be=%b wd=%h maddr=%h we=%b required err=%0d data=%h cyc=%0d mreq=%0d be=%b wd=%h maddr=%h we=%b",
                         n, op, addr, a.err, a.data, a.rcyc, a.mcyc, a.be, a.wd, a.addr, a.we,
                         e.err, e.data, e.rcyc, e.mcyc, e.be, e.wd, e.addr, e.we);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
